// File: rtl/lo_pkg.sv
// Shared types and helpers for the quadrature LO sequencer.
//   lo_state_t : controller states
//   LO_*       : 2-bit two's-complement mixer levels (+1, 0, -1)
//   lo_lut     : phase index -> {cos, sin}; sin lags cos by one step
package lo_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    HOLD
  } lo_state_t;

  localparam logic [1:0] LO_POS  = 2'b01;
  localparam logic [1:0] LO_ZERO = 2'b00;
  localparam logic [1:0] LO_NEG  = 2'b11;

  function automatic logic [3:0] lo_lut(input logic [1:0] idx);
    logic [3:0] cs;
    case (idx)
      2'd0:    cs = {LO_POS,  LO_ZERO};
      2'd1:    cs = {LO_ZERO, LO_POS};
      2'd2:    cs = {LO_NEG,  LO_ZERO};
      default: cs = {LO_ZERO, LO_NEG};
    endcase
    return cs;
  endfunction

endpackage

// File: rtl/lo_dwell_cnt.sv
// Dwell counter for the LO sequencer.
//   clk, resetn : clock, async active-low reset
//   clr         : force count to zero (has priority over en)
//   en          : count this clock
//   div         : terminal count (dwell length minus one)
//   boundary    : high while enabled and count == div (last clock of a dwell)
module lo_dwell_cnt #(
  parameter int DIV_W = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             clr,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             boundary
);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  assign boundary = en && (cnt_q == div);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = boundary ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/lo_seq_ctrl.sv
// Quadrature LO sequencer/controller for the IQ demodulator.
// Steps a 2-bit phase index every cfg_div+1 clocks and drives cos/sin levels.
//   clk, resetn            : clock, async active-low reset
//   cfg_valid/cfg_ready    : config handshake (div, dir, start phase)
//   cfg_div/cfg_dir/cfg_phase : dwell-1, step direction (1 = decrement), start index
//   start, stop            : sequencing control pulses
//   running                : high in LOAD/RUN/HOLD
//   tick                   : one-clock strobe when cos/sin take a new value
//   phase_idx, cosine_out, sine_out : registered LO outputs
module lo_seq_ctrl
  import lo_pkg::*;
#(
  parameter int DIV_W   = 4,
  parameter int DIV_RST = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic             cfg_dir,
  input  logic [1:0]       cfg_phase,
  input  logic             start,
  input  logic             stop,
  output logic             running,
  output logic             tick,
  output logic [1:0]       phase_idx,
  output logic [1:0]       cosine_out,
  output logic [1:0]       sine_out
);

  lo_state_t        state_q, state_d;
  logic             start_req_q, start_req_d;
  logic [1:0]       phase_idx_q, phase_idx_d;
  logic [1:0]       cos_q, cos_d, sin_q, sin_d;
  logic             tick_q, tick_d;
  logic             running_q, running_d;
  logic             cfg_ready_q, cfg_ready_d;
  logic [DIV_W-1:0] div_q, div_d, sh_div_q, sh_div_d;
  logic             dir_q, dir_d, sh_dir_q, sh_dir_d;
  logic [1:0]       ph_q, ph_d, sh_ph_q, sh_ph_d;
  logic             pending_q, pending_d;
  logic             cnt_clr, cnt_en, boundary, accept;
  logic [1:0]       step_idx;

  lo_dwell_cnt #(.DIV_W(DIV_W)) u_dwell (
    .clk      (clk),
    .resetn   (resetn),
    .clr      (cnt_clr),
    .en       (cnt_en),
    .div      (div_q),
    .boundary (boundary)
  );

  assign accept   = cfg_valid && cfg_ready_q;
  assign step_idx = dir_q ? phase_idx_q - 2'd1 : phase_idx_q + 2'd1;

  always_comb begin
    state_d     = state_q;
    start_req_d = 1'b0;
    phase_idx_d = phase_idx_q;
    cos_d       = cos_q;
    sin_d       = sin_q;
    tick_d      = 1'b0;
    div_d       = div_q;
    dir_d       = dir_q;
    ph_d        = ph_q;
    sh_div_d    = sh_div_q;
    sh_dir_d    = sh_dir_q;
    sh_ph_d     = sh_ph_q;
    pending_d   = pending_q;
    cnt_clr     = 1'b1;
    cnt_en      = 1'b0;

    case (state_q)
      // start is registered once before LOAD so the first outputs land two
      // edges after the start sample; stop in the same cycle cancels it.
      IDLE: begin
        if (start_req_q) state_d = LOAD;
        else             start_req_d = start && !stop;
      end
      LOAD: begin
        phase_idx_d    = ph_q;
        {cos_d, sin_d} = lo_lut(ph_q);
        tick_d         = 1'b1;
        state_d        = stop ? HOLD : RUN;
      end
      RUN: begin
        cnt_clr = 1'b0;
        cnt_en  = 1'b1;
        if (boundary) begin
          if (stop) begin
            // stop on the last clock of a dwell ends the dwell right here
            state_d = IDLE;
            cos_d   = LO_ZERO;
            sin_d   = LO_ZERO;
          end else begin
            phase_idx_d    = step_idx;
            {cos_d, sin_d} = lo_lut(step_idx);
            tick_d         = 1'b1;
          end
        end else if (stop) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        cnt_clr = 1'b0;
        cnt_en  = 1'b1;
        if (boundary) begin
          state_d = IDLE;
          cos_d   = LO_ZERO;
          sin_d   = LO_ZERO;
        end
      end
      default: state_d = IDLE;
    endcase

    // pending and accept are exclusive because cfg_ready is low while pending
    if (pending_q && (boundary || state_d == IDLE)) begin
      div_d     = sh_div_q;
      dir_d     = sh_dir_q;
      ph_d      = sh_ph_q;
      pending_d = 1'b0;
    end
    if (accept) begin
      if (state_q == IDLE || state_d == IDLE) begin
        div_d = cfg_div;
        dir_d = cfg_dir;
        ph_d  = cfg_phase;
      end else begin
        sh_div_d  = cfg_div;
        sh_dir_d  = cfg_dir;
        sh_ph_d   = cfg_phase;
        pending_d = 1'b1;
      end
    end

    running_d   = (state_d != IDLE);
    cfg_ready_d = !pending_d;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      start_req_q <= 1'b0;
      phase_idx_q <= '0;
      cos_q       <= LO_ZERO;
      sin_q       <= LO_ZERO;
      tick_q      <= 1'b0;
      running_q   <= 1'b0;
      cfg_ready_q <= 1'b1;
      div_q       <= DIV_W'(DIV_RST);
      dir_q       <= 1'b0;
      ph_q        <= '0;
      sh_div_q    <= '0;
      sh_dir_q    <= 1'b0;
      sh_ph_q     <= '0;
      pending_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      start_req_q <= start_req_d;
      phase_idx_q <= phase_idx_d;
      cos_q       <= cos_d;
      sin_q       <= sin_d;
      tick_q      <= tick_d;
      running_q   <= running_d;
      cfg_ready_q <= cfg_ready_d;
      div_q       <= div_d;
      dir_q       <= dir_d;
      ph_q        <= ph_d;
      sh_div_q    <= sh_div_d;
      sh_dir_q    <= sh_dir_d;
      sh_ph_q     <= sh_ph_d;
      pending_q   <= pending_d;
    end
  end

  assign cfg_ready  = cfg_ready_q;
  assign running    = running_q;
  assign tick       = tick_q;
  assign phase_idx  = phase_idx_q;
  assign cosine_out = cos_q;
  assign sine_out   = sin_q;

endmodule

// File: tb/tb_lo_seq_ctrl.sv
// Self-checking bench for lo_seq_ctrl: expected ticks (cycle, index, levels)
// are queued when start is driven and compared as the DUT strobes tick.
module tb_lo_seq_ctrl;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       cfg_valid = 1'b0;
  logic [3:0] cfg_div = '0;
  logic       cfg_dir = 1'b0;
  logic [1:0] cfg_phase = '0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       cfg_ready, running, tick;
  logic [1:0] phase_idx, cosine_out, sine_out;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;

  typedef struct {
    int idx;
    int cyc;
  } exp_t;
  exp_t sb[$];

  int cos_tab[4] = '{1, 0, 3, 0};
  int sin_tab[4] = '{0, 1, 0, 3};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  lo_seq_ctrl #(.DIV_W(4), .DIV_RST(4)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_div    (cfg_div),
    .cfg_dir    (cfg_dir),
    .cfg_phase  (cfg_phase),
    .start      (start),
    .stop       (stop),
    .running    (running),
    .tick       (tick),
    .phase_idx  (phase_idx),
    .cosine_out (cosine_out),
    .sine_out   (sine_out)
  );

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int nxt(input int i, input int d);
    return d != 0 ? (i + 3) % 4 : (i + 1) % 4;
  endfunction

  always @(negedge clk) begin : mon
    exp_t e;
    if (resetn === 1'b1 && tick === 1'b1) begin
      if (sb.size() == 0) begin
        check_val("spurious_tick", 1, 0);
      end else begin
        e = sb.pop_front();
        check_val("tick_cycle", cyc, e.cyc);
        check_val("tick_phase", phase_idx, e.idx);
        check_val("tick_cos", cosine_out, cos_tab[e.idx]);
        check_val("tick_sin", sine_out, sin_tab[e.idx]);
      end
    end
  end

  // Optional config, start, n expected ticks, then stop one clock into the
  // last dwell; the DUT must be idle exactly when that dwell ends.
  task automatic run_seq(input int dv, input int dr, input int ph, input int n,
                         input bit do_cfg, input bit poke);
    int c, t, idx, last_t, last_idx;
    if (do_cfg) begin
      cfg_valid = 1'b1; cfg_div = 4'(dv); cfg_dir = 1'(dr); cfg_phase = 2'(ph);
      step();
      cfg_valid = 1'b0;
    end
    start = 1'b1;
    c = cyc;
    step();
    start = 1'b0;
    idx = ph;
    t = c + 3;
    last_t = t;
    last_idx = idx;
    for (int k = 0; k < n; k++) begin
      sb.push_back('{idx, t});
      last_t = t;
      last_idx = idx;
      t += dv + 1;
      idx = nxt(idx, dr);
    end
    if (poke) begin
      while (cyc < c + 5) step();
      start = 1'b1;
      step();
      start = 1'b0;
    end
    while (cyc < last_t + (dv == 0 ? 0 : 1)) step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    if (dv >= 2) begin
      while (cyc < last_t + dv) step();
      check_val("hold_running", running, 1);
    end
    while (cyc < last_t + dv + 1) step();
    check_val("idle_running", running, 0);
    check_val("idle_cos", cosine_out, 0);
    check_val("idle_sin", sine_out, 0);
    check_val("idle_phase", phase_idx, last_idx);
    check_val("idle_ready", cfg_ready, 1);
    check_val("sb_drain", sb.size(), 0);
  endtask

  initial begin
    int c, t0, t1;
    repeat (3) step();
    check_val("rst_cos", cosine_out, 0);
    check_val("rst_sin", sine_out, 0);
    check_val("rst_phase", phase_idx, 0);
    check_val("rst_tick", tick, 0);
    check_val("rst_running", running, 0);
    check_val("rst_ready", cfg_ready, 1);
    resetn = 1'b1;
    step();

    run_seq(4, 0, 0, 5, 1'b1, 1'b1);
    run_seq(0, 1, 2, 5, 1'b1, 1'b0);

    // reset asserted mid-RUN
    start = 1'b1;
    c = cyc;
    step();
    start = 1'b0;
    sb.push_back('{2, c + 3});
    sb.push_back('{1, c + 4});
    while (cyc < c + 5) step();
    resetn = 1'b0;
    #1;
    check_val("mid_rst_cos", cosine_out, 0);
    check_val("mid_rst_sin", sine_out, 0);
    check_val("mid_rst_phase", phase_idx, 0);
    check_val("mid_rst_running", running, 0);
    check_val("mid_rst_ready", cfg_ready, 1);
    check_val("mid_rst_drain", sb.size(), 0);
    step();
    resetn = 1'b1;
    step();
    run_seq(4, 0, 0, 3, 1'b0, 1'b0);

    // reconfiguration during RUN
    cfg_valid = 1'b1; cfg_div = 4'd4; cfg_dir = 1'b0; cfg_phase = 2'd0;
    step();
    cfg_valid = 1'b0;
    start = 1'b1;
    c = cyc;
    step();
    start = 1'b0;
    t0 = c + 3;
    sb.push_back('{0, t0});
    while (cyc < t0 + 2) step();
    check_val("ready_run", cfg_ready, 1);
    cfg_valid = 1'b1; cfg_div = 4'd1; cfg_dir = 1'b1; cfg_phase = 2'd3;
    step();
    cfg_valid = 1'b0;
    check_val("ready_pending", cfg_ready, 0);
    t1 = t0 + 5;
    sb.push_back('{1, t1});
    sb.push_back('{0, t1 + 2});
    sb.push_back('{3, t1 + 4});
    sb.push_back('{2, t1 + 6});
    while (cyc < t1 - 1) step();
    check_val("ready_still_pending", cfg_ready, 0);
    step();
    check_val("ready_applied", cfg_ready, 1);
    while (cyc < t1 + 7) step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    check_val("recfg_running", running, 0);
    check_val("recfg_cos", cosine_out, 0);
    check_val("recfg_phase", phase_idx, 2);
    check_val("recfg_drain", sb.size(), 0);

    // shadowed start phase is used by the next start
    run_seq(1, 1, 3, 4, 1'b0, 1'b0);

    // start and stop together in IDLE
    start = 1'b1;
    stop = 1'b1;
    step();
    start = 1'b0;
    stop = 1'b0;
    repeat (4) step();
    check_val("ss_running", running, 0);
    check_val("ss_tick", tick, 0);
    check_val("ss_drain", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d expected fewer", cyc);
    $fatal(1);
  end

endmodule
